// File: rtl/fpga_input_conditioner_if.sv
// Board-pin / core-side signal bundle for the input conditioner.
// The slave side is the conditioner itself: it takes raw pins and returns clean levels and pulses.
// The master side is whoever drives the pins and consumes the conditioned signals.
interface fpga_input_conditioner_if #(
   parameter int NUM_BTN = 2,
   parameter int NUM_SW  = 10
);
   logic [NUM_BTN-1:0] ButtonRaw;
   logic [NUM_SW-1:0]  SwitchRaw;
   logic [NUM_BTN-1:0] ButtonPressed;
   logic [NUM_BTN-1:0] ButtonPressPulse;
   logic [NUM_BTN-1:0] ButtonReleasePulse;
   logic [NUM_SW-1:0]  SwitchStable;
   logic               SwitchChanged;
   logic [NUM_SW-1:0]  SwitchChangeMask;

   modport master (
      output ButtonRaw, SwitchRaw,
      input  ButtonPressed, ButtonPressPulse, ButtonReleasePulse,
      input  SwitchStable, SwitchChanged, SwitchChangeMask
   );

   modport slave (
      input  ButtonRaw, SwitchRaw,
      output ButtonPressed, ButtonPressPulse, ButtonReleasePulse,
      output SwitchStable, SwitchChanged, SwitchChangeMask
   );
endinterface

// File: rtl/fpga_input_conditioner.sv
// Synchronizes and debounces DE10-Lite push-buttons and slide switches for the lotr core.
// Buttons and switches share one vector of independent channels: bits [NUM_BTN-1:0] are
// buttons (active-low pins, idle at 1), the upper NUM_SW bits are switches (idle at 0).
// A channel adopts a new level only after DEBOUNCE_CYCLES consecutive cycles of disagreement;
// any cycle of agreement discards the partial count. Edge pulses and the switch change mask
// are registered one edge after the debounced level moves.
module fpga_input_conditioner #(
   parameter int NUM_BTN         = 2,
   parameter int NUM_SW          = 10,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input logic                     QClk,
   input logic                     RstQnnnH,
   fpga_input_conditioner_if.slave io
);
   localparam int                NUM_CH  = NUM_BTN + NUM_SW;
   localparam logic [NUM_CH-1:0] RST_VAL = {{NUM_SW{1'b0}}, {NUM_BTN{1'b1}}};
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_CH-1:0]  raw;
   logic [NUM_CH-1:0]  sync1;
   logic [NUM_CH-1:0]  sync2;
   logic [NUM_CH-1:0]  stable;
   logic [NUM_CH-1:0]  stable_d;
   logic [CNT_W-1:0]   cnt [NUM_CH];
   logic [NUM_BTN-1:0] press_q;
   logic [NUM_BTN-1:0] release_q;
   logic [NUM_SW-1:0]  mask_q;

   assign raw = {io.SwitchRaw, io.ButtonRaw};

   // Two-flop synchronizer on every raw pin; buttons reset to released, switches to down.
   // NOTE: reset is asynchronous so an asserted RstQnnnH clears state even without a clock edge.
   always_ff @(posedge QClk or posedge RstQnnnH) begin
      if (RstQnnnH) begin
         sync1 <= RST_VAL;
         sync2 <= RST_VAL;
      end else begin
         // NOTE: non-blocking assignment keeps sync2 one stage behind sync1; blocking would collapse the chain.
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Per-channel debounce: count cycles of disagreement, adopt sync2 on the Nth one.
   always_ff @(posedge QClk or posedge RstQnnnH) begin
      if (RstQnnnH) begin
         stable <= RST_VAL;
         // NOTE: the counter array is control state, not storage, so every entry is reset.
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Edge detection one edge after the level: press/release pulses and the switch change mask.
   always_ff @(posedge QClk or posedge RstQnnnH) begin
      if (RstQnnnH) begin
         stable_d  <= RST_VAL;
         press_q   <= '0;
         release_q <= '0;
         mask_q    <= '0;
      end else begin
         stable_d  <= stable;
         press_q   <= stable_d[NUM_BTN-1:0] & ~stable[NUM_BTN-1:0];
         release_q <= ~stable_d[NUM_BTN-1:0] & stable[NUM_BTN-1:0];
         mask_q    <= stable[NUM_CH-1:NUM_BTN] ^ stable_d[NUM_CH-1:NUM_BTN];
      end
   end

   assign io.ButtonPressed      = ~stable[NUM_BTN-1:0];
   assign io.ButtonPressPulse   = press_q;
   assign io.ButtonReleasePulse = release_q;
   assign io.SwitchStable       = stable[NUM_CH-1:NUM_BTN];
   assign io.SwitchChangeMask   = mask_q;
   assign io.SwitchChanged      = |mask_q;
endmodule

// File: tb/tb_fpga_input_conditioner.sv
// Directed bench for fpga_input_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge; "edge k" is the first edge that samples them.
// Outputs are sampled 1 time unit after each rising edge.
module tb_fpga_input_conditioner;
   localparam int N = 4;

   logic QClk;
   logic RstQnnnH;
   int   n_cmp;
   int   n_err;
   int   p0, p1, r0, r1, sc;

   fpga_input_conditioner_if #(.NUM_BTN(2), .NUM_SW(10)) io ();

   fpga_input_conditioner #(
      .NUM_BTN(2),
      .NUM_SW(10),
      .DEBOUNCE_CYCLES(N)
   ) dut (
      .QClk(QClk),
      .RstQnnnH(RstQnnnH),
      .io(io)
   );

   initial QClk = 1'b0;
   always #5 QClk = ~QClk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, sample after it, and tally every pulse seen.
   task automatic tick();
      @(posedge QClk);
      #1;
      p0 += int'(io.ButtonPressPulse[0]);
      p1 += int'(io.ButtonPressPulse[1]);
      r0 += int'(io.ButtonReleasePulse[0]);
      r1 += int'(io.ButtonReleasePulse[1]);
      sc += int'(io.SwitchChanged);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clr_counts();
      p0 = 0; p1 = 0; r0 = 0; r1 = 0; sc = 0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      clr_counts();

      // 1. Reset values, then 20 idle cycles with nothing happening.
      RstQnnnH     = 1'b1;
      io.ButtonRaw = 2'b11;
      io.SwitchRaw = 10'h000;
      ticks(3);
      chk("rst_pressed", 32'(io.ButtonPressed), 32'h0);
      chk("rst_press_pulse", 32'(io.ButtonPressPulse), 32'h0);
      chk("rst_release_pulse", 32'(io.ButtonReleasePulse), 32'h0);
      chk("rst_sw_stable", 32'(io.SwitchStable), 32'h0);
      chk("rst_sw_changed", 32'(io.SwitchChanged), 32'h0);
      chk("rst_sw_mask", 32'(io.SwitchChangeMask), 32'h0);
      RstQnnnH = 1'b0;
      clr_counts();
      ticks(20);
      chk("idle_pressed", 32'(io.ButtonPressed), 32'h0);
      chk("idle_sw_stable", 32'(io.SwitchStable), 32'h0);
      chk("idle_pulses", 32'(p0 + p1 + r0 + r1 + sc), 32'h0);

      // 2. Clean press of button 0: level at k+5, pulse after k+6.
      clr_counts();
      io.ButtonRaw = 2'b10;
      ticks(5);                                          // after edge k+4
      chk("press_level_early", 32'(io.ButtonPressed), 32'h0);
      tick();                                            // after edge k+5
      chk("press_level", 32'(io.ButtonPressed), 32'h1);
      chk("press_pulse_early", 32'(io.ButtonPressPulse), 32'h0);
      tick();                                            // after edge k+6
      chk("press_pulse", 32'(io.ButtonPressPulse), 32'h1);
      tick();                                            // after edge k+7
      chk("press_pulse_end", 32'(io.ButtonPressPulse), 32'h0);
      ticks(5);
      chk("press_pulse_count", 32'(p0), 32'd1);
      chk("press_no_release", 32'(r0 + r1 + p1), 32'h0);
      // Release so the next scenarios start from idle.
      clr_counts();
      io.ButtonRaw = 2'b11;
      ticks(10);
      chk("clean_release_count", 32'(r0), 32'd1);
      chk("clean_release_level", 32'(io.ButtonPressed), 32'h0);

      // 3. Glitch: button 1 low for N-1 cycles is rejected.
      clr_counts();
      io.ButtonRaw = 2'b01;
      ticks(3);
      io.ButtonRaw = 2'b11;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (io.ButtonPressed[1] !== 1'b0) p1 += 100;
      end
      chk("glitch_level_and_press", 32'(p1), 32'h0);
      chk("glitch_release", 32'(r1), 32'h0);

      // 4. Bounce on button 0, then settle low; one press, then one clean release.
      clr_counts();
      for (int seg = 0; seg < 6; seg++) begin
         io.ButtonRaw = (seg % 2 == 0) ? 2'b10 : 2'b11;
         ticks(2);
      end
      chk("bounce_no_press", 32'(io.ButtonPressed), 32'h0);
      io.ButtonRaw = 2'b10;
      ticks(5);                                          // after edge k+4
      chk("bounce_level_early", 32'(io.ButtonPressed), 32'h0);
      tick();                                            // after edge k+5
      chk("bounce_level", 32'(io.ButtonPressed), 32'h1);
      ticks(10);
      chk("bounce_press_count", 32'(p0), 32'd1);
      chk("bounce_release_none", 32'(r0), 32'd0);
      io.ButtonRaw = 2'b11;
      ticks(12);
      chk("bounce_release_count", 32'(r0), 32'd1);
      chk("bounce_press_total", 32'(p0), 32'd1);
      chk("bounce_released_level", 32'(io.ButtonPressed), 32'h0);

      // 5. Simultaneous switches 3 and 7 rise, then switch 3 drops alone.
      clr_counts();
      io.SwitchRaw = 10'h088;
      ticks(6);                                          // after edge k+5
      chk("sw_stable_088", 32'(io.SwitchStable), 32'h088);
      chk("sw_changed_early", 32'(io.SwitchChanged), 32'h0);
      tick();                                            // after edge k+6
      chk("sw_changed", 32'(io.SwitchChanged), 32'h1);
      chk("sw_mask_088", 32'(io.SwitchChangeMask), 32'h088);
      tick();                                            // after edge k+7
      chk("sw_mask_clear", 32'(io.SwitchChangeMask), 32'h0);
      ticks(5);
      chk("sw_change_count_a", 32'(sc), 32'd1);
      clr_counts();
      io.SwitchRaw = 10'h080;
      ticks(7);                                          // after edge k+6
      chk("sw_mask_008", 32'(io.SwitchChangeMask), 32'h008);
      chk("sw_changed_b", 32'(io.SwitchChanged), 32'h1);
      ticks(6);
      chk("sw_change_count_b", 32'(sc), 32'd1);
      chk("sw_stable_080", 32'(io.SwitchStable), 32'h080);
      chk("sw_buttons_quiet", 32'(p0 + p1 + r0 + r1), 32'h0);

      // 6. Reset mid-settle, then startup load of switch 0.
      io.SwitchRaw = 10'h001;
      ticks(2);
      RstQnnnH = 1'b1;
      #1;
      chk("midrst_sw_stable", 32'(io.SwitchStable), 32'h0);
      chk("midrst_mask", 32'(io.SwitchChangeMask), 32'h0);
      chk("midrst_pressed", 32'(io.ButtonPressed), 32'h0);
      ticks(3);
      RstQnnnH = 1'b0;
      clr_counts();
      ticks(N + 1);                                      // after edge N+1
      chk("startup_stable_early", 32'(io.SwitchStable), 32'h0);
      tick();                                            // after edge N+2
      chk("startup_stable", 32'(io.SwitchStable), 32'h001);
      tick();                                            // after edge N+3
      chk("startup_changed", 32'(io.SwitchChanged), 32'h1);
      chk("startup_mask", 32'(io.SwitchChangeMask), 32'h001);
      ticks(8);
      chk("startup_change_count", 32'(sc), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
